// File: rtl/sseg_scan_2c.sv
// rtl/sseg_scan_2c.sv - double-buffered 4-digit seven-segment scanner
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   din        four 4-bit digits, din[4k+3:4k] = digit k, digit 0 rightmost
//   sign       1 = negative, minus sign shown on digit 3
//   load       single-cycle strobe capturing din/sign into the pending buffer
//   blank_lz   1 = blank leading zeros (live, not buffered)
//   an         anode enables, active-low, one-hot-low while scanning
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, held off
//   pending    a loaded value is waiting for the next frame boundary
//   frame_done one-cycle pulse when the scan wraps from digit 3 to digit 0
module sseg_scan_2c #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        sign,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   p_din;
    logic          p_sign;
    logic [15:0]   a_din;
    logic          a_sign;

    logic          cnt_wrap;
    logic          boundary;
    logic [3:0]    cur_digit;
    logic          d3_zero;
    logic          d2_zero;
    logic          d1_zero;
    logic          d3_clear;
    logic          blank_cur;
    logic [6:0]    seg_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign cnt_wrap = (cnt == CNT_LAST);
    assign boundary = cnt_wrap && (idx == 2'd3);

    assign cur_digit = a_din[{idx, 2'b00} +: 4];
    assign d3_zero   = (a_din[15:12] == 4'h0);
    assign d2_zero   = (a_din[11:8]  == 4'h0);
    assign d1_zero   = (a_din[7:4]   == 4'h0);
    // The minus sign occupies digit 3, so it never stops blanking of the
    // zeros to its right.
    assign d3_clear  = d3_zero || a_sign;

    always_comb begin
        blank_cur = 1'b0;
        case (idx)
            2'd3:    blank_cur = blank_lz && !a_sign && d3_zero;
            2'd2:    blank_cur = blank_lz && d3_clear && d2_zero;
            2'd1:    blank_cur = blank_lz && d3_clear && d2_zero && d1_zero;
            default: blank_cur = 1'b0;
        endcase
    end

    always_comb begin
        seg_next = hex_decode(cur_digit);
        if (idx == 2'd3 && a_sign) begin
            seg_next = 7'h3F;
        end else if (blank_cur) begin
            seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            p_din      <= 16'h0000;
            p_sign     <= 1'b0;
            a_din      <= 16'h0000;
            a_sign     <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            cnt        <= cnt_wrap ? '0 : cnt + CW'(1);
            if (cnt_wrap) begin
                idx <= idx + 2'd1;
            end
            frame_done <= boundary;

            if (load) begin
                p_din  <= din;
                p_sign <= sign;
            end

            // A load landing on the boundary bypasses the pending buffer so
            // the freshest value wins over anything older still waiting.
            if (boundary && load) begin
                a_din   <= din;
                a_sign  <= sign;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                a_din   <= p_din;
                a_sign  <= p_sign;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_2c.sv
// tb/tb_sseg_scan_2c.sv - scoreboard bench for sseg_scan_2c
module tb_sseg_scan_2c;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        sign;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    sseg_scan_2c #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sign(sign), .load(load),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [27:0] segs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   frame_cnt = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] pack(input logic [6:0] d0, input logic [6:0] d1,
                                         input logic [6:0] d2, input logic [6:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Monitor: collects one frame of scanned digits, checks timing, and
    // compares content against the scoreboard entry tagged for that frame.
    always @(posedge clk) mon_en <= rst_n;

    logic [6:0] fseg [4];
    int         fcnt [4];
    int         fbad;
    int         since;

    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (!mon_en) begin
            frame_cnt = 0;
            since     = 0;
            fbad      = 0;
            for (int i = 0; i < 4; i++) fcnt[i] = 0;
        end else begin
            since++;
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k < 0) begin
                fbad = 1;
            end else begin
                if (fcnt[k] == 0) fseg[k] = seg;
                else if (fseg[k] != seg) fbad = 1;
                fcnt[k]++;
            end
            if (dp !== 1'b1) fbad = 1;
            if (frame_done) begin
                frame_cnt++;
                chk($sformatf("frame%0d_period", frame_cnt), since, 4 * DIV);
                chk($sformatf("frame%0d_stable", frame_cnt), fbad, 0);
                for (int i = 0; i < 4; i++)
                    chk($sformatf("frame%0d_dig%0d_cycles", frame_cnt, i), fcnt[i], DIV);
                while (sb.size() > 0 && sb[0].tag < frame_cnt) begin
                    chk("frame_missed", frame_cnt, sb[0].tag);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].tag == frame_cnt) begin
                    e = sb.pop_front();
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("frame%0d_dig%0d_seg", frame_cnt, i),
                            int'(fseg[i]), int'(e.segs[i*7 +: 7]));
                end
                since = 0;
                fbad  = 0;
                for (int i = 0; i < 4; i++) fcnt[i] = 0;
            end
        end
    end

    task automatic push_exp(input int tag, input logic [27:0] segs);
        sb.push_back('{tag, segs});
    endtask

    task automatic wait_frame(input int n);
        while (frame_cnt < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Caller is positioned just after a rising edge; load is held for one edge.
    task automatic do_load(input logic [15:0] d, input logic s, input bit push,
                           input logic [27:0] segs, output int tag);
        din  = d;
        sign = s;
        load = 1'b1;
        @(negedge clk);
        #1;
        tag = frame_cnt + 2;
        if (push) push_exp(tag, segs);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout actual=%0d expected=0", frame_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t;
        int t2;
        din = 16'h0; sign = 1'b0; load = 1'b0; blank_lz = 1'b1; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_pending", pending, 0);
        chk("rst_frame_done", frame_done, 0);
        push_exp(1, pack(7'h40, 7'h7F, 7'h7F, 7'h7F));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_an", an, 4'hE);
        chk("rel_seg", seg, 7'h40);
        chk("rel_pending", pending, 0);

        // Positive value with leading-zero blanking
        wait_frame(1);
        @(posedge clk); #1;
        do_load(16'h0058, 1'b0, 1'b1, pack(7'h00, 7'h12, 7'h7F, 7'h7F), t);
        chk("pos_pending_set", pending, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("pos_pending_hold", pending, 1);
        wait_frame(t - 1);
        chk("pos_pending_clear", pending, 0);
        wait_frame(t);

        // Negative value, then same value without blanking
        @(posedge clk); #1;
        do_load(16'h0079, 1'b1, 1'b1, pack(7'h10, 7'h78, 7'h7F, 7'h3F), t);
        wait_frame(t);
        @(posedge clk); #1;
        blank_lz = 1'b0;
        push_exp(t + 1, pack(7'h10, 7'h78, 7'h40, 7'h3F));
        wait_frame(t + 1);
        @(posedge clk); #1;
        blank_lz = 1'b1;

        // Last load before the boundary wins
        wait_frame(t + 2);
        @(posedge clk); #1;
        do_load(16'h0098, 1'b0, 1'b0, '0, t);
        repeat (3) @(posedge clk);
        #1;
        do_load(16'h1234, 1'b0, 1'b1, pack(7'h19, 7'h30, 7'h24, 7'h79), t2);
        push_exp(t2 + 1, pack(7'h19, 7'h30, 7'h24, 7'h79));
        wait_frame(t2 + 1);

        // Load on the boundary cycle overrides an older pending value
        @(posedge clk); #1;
        do_load(16'h0098, 1'b0, 1'b0, '0, t);
        repeat (13) @(posedge clk);
        #1;
        chk("race_pending_before", pending, 1);
        do_load(16'h0001, 1'b0, 1'b1, pack(7'h79, 7'h7F, 7'h7F, 7'h7F), t);
        chk("race_pending_after", pending, 0);
        chk("race_on_boundary", frame_done, 1);
        push_exp(t + 1, pack(7'h79, 7'h7F, 7'h7F, 7'h7F));
        wait_frame(t + 1);

        // Reset mid-frame with a load pending
        @(posedge clk); #1;
        do_load(16'h0777, 1'b0, 1'b0, '0, t);
        while (an != 4'b1011) begin
            @(negedge clk);
            #1;
        end
        chk("mid_pending", pending, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_pending", pending, 0);
        push_exp(1, pack(7'h40, 7'h7F, 7'h7F, 7'h7F));
        push_exp(2, pack(7'h40, 7'h7F, 7'h7F, 7'h7F));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_an", an, 4'hE);
        chk("mid_rel_seg", seg, 7'h40);
        chk("mid_rel_pending", pending, 0);
        wait_frame(2);

        // Hex letters
        @(posedge clk); #1;
        do_load(16'hABCF, 1'b0, 1'b1, pack(7'h0E, 7'h46, 7'h03, 7'h08), t);
        push_exp(t + 1, pack(7'h0E, 7'h46, 7'h03, 7'h08));
        wait_frame(t + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_2c.md
# sseg_scan_2c

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the two's-complement display converter. It takes the converter's 16-bit digit word (four 4-bit digits, digit 3 most significant) and its sign flag, and double-buffers each new value so that it changes only on a frame boundary. It then scans the four common-anode digits with optional leading-zero blanking and a minus sign in the leftmost position.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Must be ≥2. A frame is 4×REFRESH_DIV cycles.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  16  digit word from the converter; din[4k+3:4k] = digit k, with digit 0 rightmost.
- sign  input  1  1 = negative value; shows '-' on digit 3.
- load  input  1  single-cycle strobe; captures din/sign into the pending buffer.
- blank_lz  input  1  1 = blank leading zeros. Sampled live, not buffered.
- an  output  4  anode enables, active-low, one-hot-low while scanning.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held at 1 (off).
- pending  output  1  high while a loaded value waits for the next frame boundary.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Registers:
  - divider counter cnt, 0..REFRESH_DIV-1;
  - digit index idx, 0..3;
  - pending buffer {p_din, p_sign} plus the pending flag;
  - active buffer {a_din, a_sign}.
- Divider: cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0, and idx advances 0→1→2→3→0.
- Frame boundary = the cycle where cnt == REFRESH_DIV-1 and idx == 3. On that edge:
  - idx goes to 0 and frame_done is 1 for the next cycle;
  - if pending = 1, active ← pending buffer and pending clears.
- load = 1:
  - p_din ← din, p_sign ← sign, pending ← 1;
  - a later load before commit overwrites the buffer (last load wins).
- load coincident with a frame boundary: the newly loaded din/sign are written straight into active, and pending ends at 0. The older buffered value is discarded.
- Digit content for index k, from the active buffer:
  - k = 3 and a_sign = 1: minus sign (7'h3F).
  - k ∈ {3,2,1}, blank_lz = 1, and active digits k..3 all zero: blank (7'h7F). With a_sign = 1, digit 3 is the minus sign and does not count as a zero digit.
  - Digit 0 is never blanked.
  - Otherwise: hex decode of the digit.
- Hex decode, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78;
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- an = ~(4'b0001 << idx). an, seg and dp are registered outputs.

## Timing
- Reset (rst_n low at a clk edge) forces all of the following; reset mid-frame or with a load pending abandons both.
  - cnt = 0, idx = 0;
  - pending buffer, active buffer, pending and frame_done all 0;
  - an = 4'hF, seg = 7'h7F, dp = 1.
- Output latency: an/seg reflect idx and active from the previous cycle (1-cycle register).
  - First edge after release: an = 4'b1110, seg = 7'h40 (digit 0 = '0').
- Each digit is lit for exactly REFRESH_DIV consecutive cycles; there is no blank gap between digits.
- Load-to-display: a value committed at a frame boundary appears on digit 0 on the first cycle of the next frame. Worst case is 4×REFRESH_DIV+1 cycles after load.
- frame_done: asserted once per 4×REFRESH_DIV cycles, aligned with the cycle idx becomes 0.
- blank_lz changes take effect on the next cycle's registered output, with no frame alignment.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset hold then release: during reset an = F, seg = 7F, dp = 1. Next cycle an = E, seg = 40, pending = 0.
- Positive value: load din = 16'h0058, sign = 0, blank_lz = 1.
  - pending = 1 until the boundary.
  - Next frame: digit 0 = 00 ('8'), digit 1 = 12 ('5'), digits 2 and 3 = 7F.
  - Each digit lit 4 cycles.
- Negative value: load din = 16'h0079, sign = 1, blank_lz = 1. Next frame: digit 3 = 3F, digit 2 = 7F, digit 1 = 78, digit 0 = 10.
  - With blank_lz = 0: digit 2 = 40, digit 3 still 3F.
- Double-buffer and race: load 16'h0098, then load 16'h1234 before the boundary. Only 1234 ever displays (digits 0..3 = 19, 30, 24, 79).
  - Then a load of 16'h0001 exactly on the boundary cycle: 0001 shows in the next frame and pending stays 0.
- Reset mid-operation: assert rst_n = 0 at idx = 2 with pending = 1.
  - After release: scan restarts at digit 0 showing '0' and pending = 0.
  - The discarded value never appears.
- Hex and frame_done: load 16'hABCF, blank_lz = 1. Digits 0..3 show 0E, 46, 03, 08.
  - frame_done pulses exactly every 16 cycles.
